// File: rtl/bias_pkg.sv
// Shared constants and FSM state type for the double-buffered bias store.
// Contents: default lane count, word width and bank depth; load FSM states.
package bias_pkg;

    localparam int unsigned NCH_DEF   = 6;
    localparam int unsigned DW_DEF    = 18;
    localparam int unsigned DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWAP
    } state_e;

endpackage

// File: rtl/bias_buffer_if.sv
// Load-stream and read-port bundle of bias_buffer.
// master: load source / read requester (ld_start, ld_len, ld_data, ld_valid, rd_en, rd_addr out).
// slave : the buffer (ld_ready, ld_done, busy, rd_data, rd_valid, rd_oor, act_bank out).
interface bias_buffer_if
    import bias_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = $clog2(DEPTH_DEF)
) ();

    logic                ld_start;
    logic [AW:0]         ld_len;
    logic [DW-1:0]       ld_data;
    logic                ld_valid;
    logic                ld_ready;
    logic                ld_done;
    logic                busy;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [NCH*DW-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_oor;
    logic                act_bank;

    modport master (
        output ld_start, ld_len, ld_data, ld_valid, rd_en, rd_addr,
        input  ld_ready, ld_done, busy, rd_data, rd_valid, rd_oor, act_bank
    );

    modport slave (
        input  ld_start, ld_len, ld_data, ld_valid, rd_en, rd_addr,
        output ld_ready, ld_done, busy, rd_data, rd_valid, rd_oor, act_bank
    );

endinterface

// File: rtl/bias_bank.sv
// One bias bank: DEPTH entries of NCH lanes x DW bits, synchronous RAM.
// Ports: clk, rst (sync, clears only the read register), we_i (per-lane write
// enable), waddr_i, wdata_i (one lane word), re_i, raddr_i, rdata_o (registered).
// The read register loads zero when re_i is low, so two banks can be merged
// with a plain OR downstream.
module bias_bank #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned DW    = 18,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [NCH*DW-1:0] rdata_o
);

    logic [NCH-1:0][DW-1:0] mem_q [DEPTH];
    logic [NCH*DW-1:0]      rdata_q;

    // Lane-granular write; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (we_i[c]) begin
                mem_q[waddr_i][c] <= wdata_i;
            end
        end
    end

    // Registered read, zero when not selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bias_buffer.sv
// Double-buffered per-channel bias store.
// Ports: clk, rst (sync, active-high), bus (bias_buffer_if.slave):
//   load stream ld_start/ld_len/ld_data/ld_valid/ld_ready, status ld_done/busy/act_bank,
//   read port rd_en/rd_addr -> rd_data/rd_valid/rd_oor one cycle later.
// Loads fill the shadow bank lane by lane; a one-cycle SWAP makes it active.
module bias_buffer
    import bias_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    bias_buffer_if.slave bus
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);

    state_e            state_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     active_len_q;
    logic [AW-1:0]     ent_cnt_q;
    logic [CW-1:0]     ch_cnt_q;
    logic              act_bank_q;
    logic              ld_ready_q;
    logic              ld_done_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic              rd_oor_q;

    logic              beat_c;
    logic              last_beat_c;
    logic [LW-1:0]     len_clamp_c;
    logic [NCH-1:0]    lane_we_c;
    logic              rd_in_range_c;
    logic [NCH*DW-1:0] rdata0_c;
    logic [NCH*DW-1:0] rdata1_c;

    assign beat_c      = (state_q == LOAD) && bus.ld_valid;
    assign last_beat_c = beat_c && (ch_cnt_q == CH_LAST)
                         && ({1'b0, ent_cnt_q} == (len_q - LW'(1)));
    assign len_clamp_c = (bus.ld_len > DEPTH_L) ? DEPTH_L : bus.ld_len;

    // Load FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            active_len_q <= '0;
            ent_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            act_bank_q   <= 1'b0;
            ld_ready_q   <= 1'b0;
            ld_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ld_start) begin
                        len_q     <= len_clamp_c;
                        ent_cnt_q <= '0;
                        ch_cnt_q  <= '0;
                        busy_q    <= 1'b1;
                        if (len_clamp_c == '0) begin
                            state_q <= SWAP;
                        end else begin
                            state_q    <= LOAD;
                            ld_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat_c) begin
                        if (ch_cnt_q == CH_LAST) begin
                            ch_cnt_q  <= '0;
                            ent_cnt_q <= ent_cnt_q + AW'(1);
                        end else begin
                            ch_cnt_q <= ch_cnt_q + CW'(1);
                        end
                        if (last_beat_c) begin
                            state_q    <= SWAP;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                SWAP: begin
                    state_q      <= IDLE;
                    act_bank_q   <= ~act_bank_q;
                    active_len_q <= len_q;
                    ld_done_q    <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One-hot lane select for the current load beat.
    always_comb begin
        lane_we_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            lane_we_c[c] = beat_c && (ch_cnt_q == CW'(c));
        end
    end

    assign rd_in_range_c = ({1'b0, bus.rd_addr} < active_len_q);

    // Writes go to the shadow bank; only the active bank is read.
    bias_bank #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (act_bank_q ? lane_we_c : '0),
        .waddr_i (ent_cnt_q),
        .wdata_i (bus.ld_data),
        .re_i    (bus.rd_en && rd_in_range_c && !act_bank_q),
        .raddr_i (bus.rd_addr),
        .rdata_o (rdata0_c)
    );

    bias_bank #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (act_bank_q ? '0 : lane_we_c),
        .waddr_i (ent_cnt_q),
        .wdata_i (bus.ld_data),
        .re_i    (bus.rd_en && rd_in_range_c && act_bank_q),
        .raddr_i (bus.rd_addr),
        .rdata_o (rdata1_c)
    );

    // Read qualifiers captured alongside the bank read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            rd_oor_q   <= bus.rd_en && !rd_in_range_c;
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.busy     = busy_q;
    assign bus.act_bank = act_bank_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_oor   = rd_oor_q;
    // At most one bank register is non-zero, out-of-range reads leave both zero.
    assign bus.rd_data  = rdata0_c | rdata1_c;

endmodule

// File: tb/tb_bias_buffer.sv
// Self-checking bench for bias_buffer: directed load/read scenarios, a
// transaction-level model checked every cycle, plus literal expectations.
module tb_bias_buffer;
    import bias_pkg::*;

    localparam int unsigned NCH   = 6;
    localparam int unsigned DW    = 18;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned W     = NCH * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bias_buffer_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

    bias_buffer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_bank [2][DEPTH][NCH];
    bit              m_act;
    int              m_len;
    int              m_ld_len;
    int              m_rem;
    int              m_beat;
    bit              m_swap;
    bit              model_on = 1'b0;
    bit              e_ready, e_busy, e_done, e_act, e_rv, e_oor;
    logic [W-1:0]    e_data;

    always @(posedge clk) begin : model_step
        int n;
        if (rst) begin
            m_act = 1'b0; m_len = 0; m_rem = 0; m_swap = 1'b0;
            e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_act = 1'b0;
            e_rv = 1'b0; e_oor = 1'b0; e_data = '0;
            model_on = 1'b1;
        end else begin
            e_rv = bus.rd_en; e_oor = 1'b0; e_data = '0;
            if (bus.rd_en) begin
                if (int'(bus.rd_addr) < m_len) begin
                    for (int c = 0; c < NCH; c++)
                        e_data[c*DW +: DW] = DW'(m_bank[m_act][bus.rd_addr][c]);
                end else begin
                    e_oor = 1'b1;
                end
            end
            e_done = 1'b0;
            if (m_swap) begin
                m_act = !m_act; m_len = m_ld_len; e_done = 1'b1; m_swap = 1'b0;
            end else if (m_rem > 0) begin
                if (bus.ld_valid) begin
                    m_bank[!m_act][m_beat / NCH][m_beat % NCH] = int'(bus.ld_data);
                    m_beat++; m_rem--;
                    if (m_rem == 0) m_swap = 1'b1;
                end
            end else if (bus.ld_start) begin
                n = int'(bus.ld_len);
                if (n > DEPTH) n = DEPTH;
                m_ld_len = n; m_beat = 0;
                if (n == 0) m_swap = 1'b1;
                else m_rem = n * NCH;
            end
            e_ready = (m_rem > 0);
            e_busy  = (m_rem > 0) || m_swap;
            e_act   = m_act;
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (model_on) begin
            chk("act_bank", W'(bus.act_bank), W'(e_act));
            chk("busy",     W'(bus.busy),     W'(e_busy));
            chk("ld_ready", W'(bus.ld_ready), W'(e_ready));
            chk("ld_done",  W'(bus.ld_done),  W'(e_done));
            chk("rd_valid", W'(bus.rd_valid), W'(e_rv));
            if (e_rv) begin
                chk("rd_oor",  W'(bus.rd_oor), W'(e_oor));
                chk("rd_data", bus.rd_data,    e_data);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] lanes(input int base);
        logic [W-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*DW +: DW] = DW'(base + c);
        return v;
    endfunction

    initial begin
        int acc;
        int beat;
        int cyc;
        bit pulsed;
        bit done_seen;
        logic [W-1:0] rv;

        rst = 1'b1;
        bus.ld_start = 1'b0; bus.ld_len = '0; bus.ld_data = '0; bus.ld_valid = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        repeat (3) tick();
        chk("rst busy",     W'(bus.busy),     W'(0));
        chk("rst ld_ready", W'(bus.ld_ready), W'(0));
        chk("rst ld_done",  W'(bus.ld_done),  W'(0));
        chk("rst rd_valid", W'(bus.rd_valid), W'(0));
        chk("rst rd_data",  bus.rd_data,      W'(0));
        chk("rst act_bank", W'(bus.act_bank), W'(0));
        rst = 1'b0;

        // Reads straight after reset are out of range.
        bus.rd_en = 1'b1; bus.rd_addr = AW'(0);
        tick();
        chk("post-rst rd_valid", W'(bus.rd_valid), W'(1));
        chk("post-rst oor a0",   W'(bus.rd_oor),   W'(1));
        chk("post-rst data a0",  bus.rd_data,      W'(0));
        bus.rd_addr = AW'(511);
        tick();
        chk("post-rst oor a511", W'(bus.rd_oor),   W'(1));
        chk("post-rst data a511", bus.rd_data,     W'(0));
        bus.rd_en = 1'b0;

        // Load 1: len 4, words k+1, valid held high.
        bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(4);
        tick();
        bus.ld_start = 1'b0;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            bus.ld_valid = 1'b1; bus.ld_data = DW'(k + 1);
            if (bus.ld_ready) acc++;
            tick();
        end
        bus.ld_valid = 1'b0;
        chk("load1 beats", W'(acc), W'(24));
        chk("load1 swap done", W'(bus.ld_done), W'(0));
        chk("load1 swap busy", W'(bus.busy), W'(1));
        tick();
        chk("load1 done", W'(bus.ld_done), W'(1));
        chk("load1 act", W'(bus.act_bank), W'(1));
        tick();
        chk("load1 done drop", W'(bus.ld_done), W'(0));
        bus.rd_en = 1'b1; bus.rd_addr = AW'(2);
        tick();
        chk("load1 a2 data", bus.rd_data, lanes(13));
        chk("load1 a2 oor", W'(bus.rd_oor), W'(0));
        bus.rd_addr = AW'(4);
        tick();
        chk("load1 a4 oor", W'(bus.rd_oor), W'(1));
        chk("load1 a4 data", bus.rd_data, W'(0));
        bus.rd_en = 1'b0;

        // Load 2: len 2, valid every other cycle, reads running throughout.
        bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(2);
        tick();
        bus.ld_start = 1'b0;
        beat = 0;
        for (int i = 0; i < 64 && beat < 12; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = AW'(i % 4);
            bus.ld_valid = (i % 2 == 0);
            if (bus.ld_valid) begin
                bus.ld_data = DW'(200 + beat);
                beat++;
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.rd_addr = AW'(0);       // issued in the SWAP cycle
        tick();
        chk("swap-cycle read old", bus.rd_data, lanes(1));
        chk("load2 done", W'(bus.ld_done), W'(1));
        bus.rd_addr = AW'(0);       // issued after the swap
        tick();
        chk("post-swap read new", bus.rd_data, lanes(200));
        bus.rd_addr = AW'(2);
        tick();
        chk("load2 a2 oor", W'(bus.rd_oor), W'(1));
        bus.rd_en = 1'b0;

        // Load 3: len 600 clamps to 512; a second ld_start mid-load is ignored.
        bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(600);
        tick();
        bus.ld_start = 1'b0;
        acc = 0; cyc = 0; pulsed = 1'b0;
        while (cyc < 4000 && !(acc > 0 && !bus.ld_ready)) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = DW'(acc * 7 + 3);
            if (acc == 100 && !pulsed) begin
                bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(3); pulsed = 1'b1;
            end else begin
                bus.ld_start = 1'b0;
            end
            if (bus.ld_ready) acc++;
            tick();
            cyc++;
        end
        bus.ld_valid = 1'b0; bus.ld_start = 1'b0;
        chk("clamp beats", W'(acc), W'(3072));
        chk("clamp swap busy", W'(bus.busy), W'(1));
        tick();
        chk("clamp done", W'(bus.ld_done), W'(1));
        bus.rd_en = 1'b1; bus.rd_addr = AW'(511);
        tick();
        rv = bus.rd_data;
        chk("clamp a511 oor", W'(bus.rd_oor), W'(0));
        chk("clamp a511 lane5", W'(rv[5*DW +: DW]), W'(21500));
        bus.rd_en = 1'b0;

        // Reset in the middle of a load.
        bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(4);
        tick();
        bus.ld_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.ld_valid = 1'b1; bus.ld_data = DW'(500 + k);
            tick();
        end
        rst = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = AW'(0);
        tick();
        rst = 1'b0; bus.rd_en = 1'b0; bus.ld_valid = 1'b0;
        chk("abort busy", W'(bus.busy), W'(0));
        chk("abort act", W'(bus.act_bank), W'(0));
        chk("abort ld_ready", W'(bus.ld_ready), W'(0));
        chk("rd during rst", W'(bus.rd_valid), W'(0));
        done_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.ld_done) done_seen = 1'b1;
        end
        chk("abort no done", W'(done_seen), W'(0));
        bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
        tick();
        chk("abort read oor", W'(bus.rd_oor), W'(1));
        bus.rd_en = 1'b0;

        // Zero-length load swaps without a data phase.
        bus.ld_start = 1'b1; bus.ld_len = (AW+1)'(0);
        tick();
        bus.ld_start = 1'b0;
        chk("len0 ld_ready", W'(bus.ld_ready), W'(0));
        chk("len0 busy", W'(bus.busy), W'(1));
        tick();
        chk("len0 done", W'(bus.ld_done), W'(1));
        chk("len0 act", W'(bus.act_bank), W'(1));
        bus.rd_en = 1'b1; bus.rd_addr = AW'(0);
        tick();
        chk("len0 a0 oor", W'(bus.rd_oor), W'(1));
        bus.rd_en = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bias_buffer.md
Name: bias_buffer

Overview:
- Parametrised, double-buffered per-channel bias store for the accumulator datapath.
- Generalises the fixed 6-lane, 18-bit, read-only bias memory:
  - channel count, width and depth are parameters;
  - bias values are loaded at run time over a valid/ready stream into a shadow bank;
  - the shadow bank swaps in atomically while the active bank keeps serving reads;
  - out-of-range reads are flagged.

Parameters:
- NCH, 6: number of output channels (lanes).
- DW, 18: bias word width per channel.
- DEPTH, 512: entries per bank.
- AW, $clog2(DEPTH): address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  one-cycle pulse; begins a load of ld_len entries into the shadow bank.
- ld_len  in  AW+1  number of entries to load; sampled on ld_start.
- ld_data  in  DW  one bias word, channel-interleaved.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  buffer accepts ld_data.
- ld_done  out  1  one-cycle pulse in the cycle the bank swap takes effect.
- busy  out  1  load in progress.
- rd_en  in  1  read request.
- rd_addr  in  AW  entry index.
- rd_data  out  NCH*DW  all channels of one entry; lane c is bits [c*DW +: DW].
- rd_valid  out  1  rd_data valid.
- rd_oor  out  1  qualifies rd_valid; address was >= active length.
- act_bank  out  1  index of the bank currently serving reads.

Behaviour:
- Reset values:
  - state IDLE; act_bank 0; active_len 0.
  - ld_ready, ld_done, busy, rd_valid, rd_oor all 0; rd_data 0.
- RAM contents are not cleared by reset. Because active_len is 0, every read after reset returns zeros with rd_oor=1.
- FSM states:
  - IDLE:
    - ld_start with ld_len>0 -> LOAD. Capture len; ent_cnt=0, ch_cnt=0.
    - ld_start with ld_len==0 -> SWAP.
  - LOAD:
    - ld_ready=1, busy=1.
    - Each ld_valid&&ld_ready beat writes ld_data to shadow bank entry ent_cnt, lane ch_cnt.
    - ch_cnt wraps at NCH-1; on wrap, ent_cnt increments.
    - The beat carrying ent_cnt==len-1 and ch_cnt==NCH-1 -> SWAP.
  - SWAP (1 cycle):
    - busy=1, ld_ready=0.
    - At the end of the cycle: act_bank toggles, active_len=len, ld_done=1 in the following IDLE cycle.
- ld_len > DEPTH is clamped to DEPTH.
- ld_start outside IDLE is ignored.
- ld_valid outside LOAD is dropped; ld_ready=0 there.
- Writes are per-lane. The bias_bank write-enable selects lane ch_cnt only; other lanes of that entry are untouched.
- Read path:
  - rd_en in cycle N: rd_valid=1, rd_data and rd_oor are valid in cycle N+1 (1-cycle latency, registered).
  - Fully pipelined: one read per cycle. rd_valid=0 when rd_en was 0.
  - The bank index and the in-range comparison are captured with rd_en. A read issued in the SWAP cycle returns the old bank; a read issued in the next cycle returns the new bank.
  - rd_addr >= active_len: rd_data=0, rd_oor=1.
- Loads only touch the shadow bank, so reads and loads never collide in any cycle.
- rst asserted mid-load:
  - load is aborted; state IDLE; act_bank 0; active_len 0.
  - partially written shadow data is never exposed.
- rd_en during rst: rd_valid=0 in the next cycle.

Decomposition:
- Package bias_pkg holds:
  - default constants NCH_DEF=6, DW_DEF=18, DEPTH_DEF=512;
  - the FSM state enum {IDLE, LOAD, SWAP}.
- Sub-module bias_bank:
  - one bank, synchronous RAM, NCH*DW wide, DEPTH deep;
  - per-lane write enable, 1-cycle registered read;
  - instantiated twice.
- The top level holds the FSM, the counters, the bank mux and the out-of-range logic.

Test Plan:
- Reset, then rd_en at addr 0 and addr 511 -> rd_valid next cycle, rd_data=0, rd_oor=1, act_bank=0.
- Load len=4 with words k=0..23 (value=k+1), ld_valid held high -> 24 beats accepted on consecutive cycles; ld_done 2 cycles after the last beat; act_bank=1; read addr 2 returns lane c = 13+c; addr 4 -> rd_oor=1.
- During a second load (len=2, ld_valid toggling every other cycle), issue back-to-back reads of addr 0..3 -> old bank data returned each cycle. A read issued in the SWAP cycle returns old data; a read in the next cycle returns new data.
- ld_start pulsed again mid-load, and ld_len=600 -> second pulse ignored; length clamped to 512, with busy held for 512*6 beats.
- rst asserted after 10 beats of a load -> busy=0, act_bank=0, active_len=0, ld_done never pulses; subsequent reads return rd_oor=1.
- ld_start with ld_len=0 -> no ld_ready; ld_done 2 cycles later; act_bank toggles; all reads return rd_oor=1.
